// File: rtl/color_matrix_pipe.sv
// -----------------------------------------------------------------------------
// color_matrix_pipe
//
// Four-stage pipelined 3x3 colour-matrix transform for the video path.
// Modes: bypass, sepia, grayscale and custom (programmable, double-buffered
// coefficients). Mode and coefficient changes are committed only on
// frame_start, so a frame is always processed with a single configuration.
//
// Ports:
//   clk          system clock, all state on posedge
//   rst          asynchronous reset, active low
//   in_valid     input pixel qualifier
//   r_in/g_in/b_in  input pixel, DATA_W bits per channel (unsigned)
//   frame_start  one-cycle pulse committing shadow config to active config
//   mode         requested mode (0 bypass, 1 sepia, 2 grayscale, 3 custom)
//   cfg_we       shadow coefficient write strobe
//   cfg_addr     coefficient index 0..8 row-major (R row, G row, B row);
//                9..15 ignored
//   cfg_data     signed coefficient, FRAC_W fractional bits
//   out_valid    output pixel qualifier, in_valid delayed by 4 cycles
//   r_out/g_out/b_out  transformed pixel; holds the last valid pixel
//
// Build option:
//   CMX_ROUND_EN  when defined, row sums get +2^(FRAC_W-1) before the final
//                 shift (round half up); otherwise the shift is a pure floor.
// -----------------------------------------------------------------------------
module color_matrix_pipe #(
    parameter int DATA_W = 8,
    parameter int COEF_W = 10,
    parameter int FRAC_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] r_in,
    input  logic [DATA_W-1:0] g_in,
    input  logic [DATA_W-1:0] b_in,
    input  logic              frame_start,
    input  logic [1:0]        mode,
    input  logic              cfg_we,
    input  logic [3:0]        cfg_addr,
    input  logic [COEF_W-1:0] cfg_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] r_out,
    output logic [DATA_W-1:0] g_out,
    output logic [DATA_W-1:0] b_out
);

    localparam int PROD_W = DATA_W + COEF_W + 1;
    localparam int SUM_W  = PROD_W + 2;

    typedef enum logic [1:0] {
        MODE_BYPASS = 2'd0,
        MODE_SEPIA  = 2'd1,
        MODE_GRAY   = 2'd2,
        MODE_CUSTOM = 2'd3
    } mode_e;

    typedef logic signed [COEF_W-1:0] coef_t;
    typedef logic signed [PROD_W-1:0] prod_t;
    typedef logic signed [SUM_W-1:0]  sum_t;

    // Built-in matrices are expressed for FRAC_W = 8 and rescaled below.
    localparam int SEPIA_TAB [9] = '{101, 197, 48, 89, 176, 43, 70, 137, 33};
    localparam int GRAY_TAB  [9] = '{77, 150, 29, 77, 150, 29, 77, 150, 29};

    localparam coef_t ONE     = coef_t'(1 <<< FRAC_W);
    localparam sum_t  PIX_MAX = sum_t'((1 << DATA_W) - 1);

`ifdef CMX_ROUND_EN
    localparam sum_t ROUND_K = sum_t'(1 <<< (FRAC_W - 1));
`endif

    function automatic coef_t scale_coef(input int c);
        if (FRAC_W >= 8) begin
            return coef_t'(c <<< (FRAC_W - 8));
        end
        return coef_t'(c >>> (8 - FRAC_W));
    endfunction

    // Row-major 3x3: indices 0, 4 and 8 are the diagonal.
    function automatic coef_t identity_coef(input int idx);
        return ((idx % 4) == 0) ? ONE : '0;
    endfunction

    function automatic sum_t sext_prod(input prod_t p);
        return {{2{p[PROD_W-1]}}, p};
    endfunction

    // Floor shift, then saturate into the unsigned pixel range.
    function automatic logic [DATA_W-1:0] clamp_px(input sum_t s);
        sum_t q;
        q = s >>> FRAC_W;
        if (q[SUM_W-1]) begin
            return '0;
        end
        if (q > PIX_MAX) begin
            return '1;
        end
        return q[DATA_W-1:0];
    endfunction

    // -------------------------------------------------------------------------
    // Configuration: active and shadow banks
    // -------------------------------------------------------------------------
    mode_e active_mode;
    coef_t active_bank [9];
    coef_t shadow_bank [9];

    // NOTE: the coefficient banks are small register arrays, not RAM, so they
    // are reset like any other flop; the identity value is needed from reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            active_mode <= MODE_BYPASS;
            for (int i = 0; i < 9; i++) begin
                active_bank[i] <= identity_coef(i);
                shadow_bank[i] <= identity_coef(i);
            end
        end else begin
            // NOTE: non-blocking assignments make the commit copy the shadow
            // bank as it stood before a coincident cfg_we write lands.
            if (frame_start) begin
                active_mode <= mode_e'(mode);
                active_bank <= shadow_bank;
            end
            if (cfg_we && (cfg_addr <= 4'd8)) begin
                shadow_bank[cfg_addr] <= cfg_data;
            end
        end
    end

    // A pixel arriving together with frame_start already sees the new config.
    mode_e sel_mode;
    coef_t sel_coef [9];

    // NOTE: every output of this block is given a value before any branch, so
    // no path leaves a variable unassigned and no latch is inferred.
    always_comb begin
        sel_mode = frame_start ? mode_e'(mode) : active_mode;
        for (int i = 0; i < 9; i++) begin
            sel_coef[i] = identity_coef(i);
            case (sel_mode)
                MODE_SEPIA:  sel_coef[i] = scale_coef(SEPIA_TAB[i]);
                MODE_GRAY:   sel_coef[i] = scale_coef(GRAY_TAB[i]);
                MODE_CUSTOM: sel_coef[i] = frame_start ? shadow_bank[i] : active_bank[i];
                default:     sel_coef[i] = identity_coef(i);
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // S1: pixel and its own coefficient set
    // -------------------------------------------------------------------------
    logic              s1_valid;
    logic [DATA_W-1:0] s1_pix  [3];
    coef_t             s1_coef [9];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                s1_pix[i] <= '0;
            end
            for (int i = 0; i < 9; i++) begin
                s1_coef[i] <= '0;
            end
        end else begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_pix[0] <= r_in;
                s1_pix[1] <= g_in;
                s1_pix[2] <= b_in;
                s1_coef   <= sel_coef;
            end
        end
    end

    // -------------------------------------------------------------------------
    // S2: nine signed products, pixel zero-extended
    // -------------------------------------------------------------------------
    prod_t prod_next [9];

    always_comb begin
        for (int i = 0; i < 9; i++) begin
            prod_next[i] = $signed({{(COEF_W + 1){1'b0}}, s1_pix[i % 3]})
                         * $signed({{(DATA_W + 1){s1_coef[i][COEF_W-1]}}, s1_coef[i]});
        end
    end

    logic  s2_valid;
    prod_t s2_prod [9];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2_valid <= 1'b0;
            for (int i = 0; i < 9; i++) begin
                s2_prod[i] <= '0;
            end
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_prod <= prod_next;
            end
        end
    end

    // -------------------------------------------------------------------------
    // S3: full-precision row sums (optionally pre-biased for rounding)
    // -------------------------------------------------------------------------
    sum_t sum_next [3];

    always_comb begin
        for (int r = 0; r < 3; r++) begin
            sum_next[r] = sext_prod(s2_prod[3*r])
                        + sext_prod(s2_prod[3*r+1])
                        + sext_prod(s2_prod[3*r+2]);
`ifdef CMX_ROUND_EN
            sum_next[r] = sum_next[r] + ROUND_K;
`endif
        end
    end

    logic s3_valid;
    sum_t s3_sum [3];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s3_valid <= 1'b0;
            for (int r = 0; r < 3; r++) begin
                s3_sum[r] <= '0;
            end
        end else begin
            s3_valid <= s2_valid;
            if (s2_valid) begin
                s3_sum <= sum_next;
            end
        end
    end

    // -------------------------------------------------------------------------
    // S4: shift, clamp and register the outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            r_out     <= '0;
            g_out     <= '0;
            b_out     <= '0;
        end else begin
            out_valid <= s3_valid;
            if (s3_valid) begin
                r_out <= clamp_px(s3_sum[0]);
                g_out <= clamp_px(s3_sum[1]);
                b_out <= clamp_px(s3_sum[2]);
            end
        end
    end

endmodule

// File: tb/tb_color_matrix_pipe.sv
// -----------------------------------------------------------------------------
// tb_color_matrix_pipe
//
// Directed stimulus for color_matrix_pipe. A behavioural model (mode/bank
// bookkeeping, integer matrix arithmetic with floor division, and a 4-deep
// delay line) predicts out_valid and the pixel on every cycle; a compare
// process checks the DUT against it on each falling edge. Hand-computed
// literal pixels pin the model for each scenario.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_color_matrix_pipe;

    localparam int DATA_W = 8;
    localparam int COEF_W = 10;
    localparam int FRAC_W = 8;

`ifdef CMX_ROUND_EN
    localparam int SMALL_R  = 1;  // sepia (2,0,0): R = 202/256 rounded
    localparam int SMALL_GB = 1;
    localparam int GRAY_RED = 77; // 77*255/256 = 76.7 rounded
`else
    localparam int SMALL_R  = 0;
    localparam int SMALL_GB = 0;
    localparam int GRAY_RED = 76;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              in_valid = 1'b0;
    logic [DATA_W-1:0] r_in = '0;
    logic [DATA_W-1:0] g_in = '0;
    logic [DATA_W-1:0] b_in = '0;
    logic              frame_start = 1'b0;
    logic [1:0]        mode = 2'd0;
    logic              cfg_we = 1'b0;
    logic [3:0]        cfg_addr = '0;
    logic [COEF_W-1:0] cfg_data = '0;
    logic              out_valid;
    logic [DATA_W-1:0] r_out;
    logic [DATA_W-1:0] g_out;
    logic [DATA_W-1:0] b_out;

    always #5 clk = ~clk;

    color_matrix_pipe #(
        .DATA_W(DATA_W),
        .COEF_W(COEF_W),
        .FRAC_W(FRAC_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .r_in       (r_in),
        .g_in       (g_in),
        .b_in       (b_in),
        .frame_start(frame_start),
        .mode       (mode),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .out_valid  (out_valid),
        .r_out      (r_out),
        .g_out      (g_out),
        .b_out      (b_out)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // -------------------------------------------------------------------------
    // Behavioural model
    // -------------------------------------------------------------------------
    typedef struct {
        bit v;
        int r;
        int g;
        int b;
    } px_t;

    localparam int SEPIA_M [9] = '{101, 197, 48, 89, 176, 43, 70, 137, 33};
    localparam int GRAY_M  [9] = '{77, 150, 29, 77, 150, 29, 77, 150, 29};

    int  m_mode;
    int  m_active [9];
    int  m_shadow [9];
    px_t m_line [$];
    px_t m_exp = '{0, 0, 0, 0};
    px_t got [$];

    function automatic int to_pixel(input int s);
        int q;
        q = s / 256;
        if (s < 0 && (s % 256) != 0) q = q - 1;  // floor, not truncate
        if (q < 0) return 0;
        if (q > 255) return 255;
        return q;
    endfunction

    always @(posedge clk) begin
        if (!rst) begin
            m_mode = 0;
            for (int i = 0; i < 9; i++) begin
                m_active[i] = (i == 0 || i == 4 || i == 8) ? 256 : 0;
                m_shadow[i] = m_active[i];
            end
            m_line.delete();
            m_exp = '{0, 0, 0, 0};
        end else begin
            px_t nx;
            px_t h;
            int  md;
            int  cf [9];
            int  pin [3];
            int  res [3];
            int  s;
            int  c;
            md = frame_start ? int'(mode) : m_mode;
            for (int i = 0; i < 9; i++) cf[i] = frame_start ? m_shadow[i] : m_active[i];
            pin[0] = int'(r_in);
            pin[1] = int'(g_in);
            pin[2] = int'(b_in);
            for (int row = 0; row < 3; row++) begin
                if (md == 0) begin
                    res[row] = pin[row];
                end else begin
                    s = 0;
                    for (int k = 0; k < 3; k++) begin
                        c = (md == 1) ? SEPIA_M[3*row+k] : (md == 2) ? GRAY_M[3*row+k] : cf[3*row+k];
                        s = s + c * pin[k];
                    end
`ifdef CMX_ROUND_EN
                    s = s + 128;
`endif
                    res[row] = to_pixel(s);
                end
            end
            nx = '{in_valid, res[0], res[1], res[2]};
            m_line.push_back(nx);
            if (m_line.size() == 4) begin
                h = m_line.pop_front();
                m_exp.v = h.v;
                if (h.v) begin
                    m_exp.r = h.r;
                    m_exp.g = h.g;
                    m_exp.b = h.b;
                end
            end
            if (frame_start) begin
                m_mode   = int'(mode);
                m_active = m_shadow;
            end
            if (cfg_we && cfg_addr <= 4'd8) m_shadow[cfg_addr] = int'($signed(cfg_data));
        end
    end

    // Per-cycle comparison against the model; valid outputs are also captured
    // for the literal expectations below.
    always @(negedge clk) begin
        check("out_valid", int'(out_valid), int'(m_exp.v));
        check("r_out", int'(r_out), m_exp.r);
        check("g_out", int'(g_out), m_exp.g);
        check("b_out", int'(b_out), m_exp.b);
        if (out_valid) got.push_back('{1'b1, int'(r_out), int'(g_out), int'(b_out)});
    end

    // -------------------------------------------------------------------------
    // Stimulus helpers (drive on the falling edge)
    // -------------------------------------------------------------------------
    task automatic drive(input bit v, input int r, input int g, input int b,
                         input bit fs, input int md,
                         input bit we, input int addr, input int data);
        @(negedge clk);
        in_valid    = v;
        r_in        = DATA_W'(r);
        g_in        = DATA_W'(g);
        b_in        = DATA_W'(b);
        frame_start = fs;
        mode        = 2'(md);
        cfg_we      = we;
        cfg_addr    = 4'(addr);
        cfg_data    = COEF_W'(data);
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic send(input int r, input int g, input int b);
        drive(1, r, g, b, 0, 0, 0, 0, 0);
    endtask

    task automatic commit(input int md);
        drive(0, 0, 0, 0, 1, md, 0, 0, 0);
    endtask

    task automatic write(input int addr, input int data);
        drive(0, 0, 0, 0, 0, 0, 1, addr, data);
    endtask

    task automatic expect_px(input string name, input int r, input int g, input int b);
        int  waited;
        px_t p;
        waited = 0;
        while (got.size() == 0 && waited < 20) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (got.size() == 0) begin
            check({name, "_timeout"}, 0, 1);
        end else begin
            p = got.pop_front();
            check({name, "_r"}, p.r, r);
            check({name, "_g"}, p.g, g);
            check({name, "_b"}, p.b, b);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_r_out", int'(r_out), 0);
        check("rst_b_out", int'(b_out), 0);
        #2 rst = 1'b1;

        // Bypass after reset
        send(10, 20, 30);
        idle();
        expect_px("bypass", 10, 20, 30);

        // Sepia, including the clamp and the floor/round boundary
        commit(1);
        send(100, 150, 200);
        send(255, 255, 255);
        send(2, 0, 0);
        idle();
        expect_px("sepia", 192, 171, 133);
        expect_px("sepia_clamp", 255, 255, 239);
        expect_px("sepia_small", SMALL_R, SMALL_GB, SMALL_GB);

        // Custom writes without a commit leave sepia active; addr 12 ignored
        write(0, 256);
        write(1, -256);
        write(12, 0);
        send(50, 80, 0);
        idle();
        expect_px("no_commit", 81, 72, 56);

        commit(3);
        send(50, 80, 0);
        idle();
        expect_px("custom_neg", 0, 80, 0);

        // cfg_we coincident with frame_start (and a pixel in the same cycle)
        drive(1, 50, 80, 0, 1, 3, 1, 4, 0);
        idle();
        expect_px("coincident_we", 0, 80, 0);
        commit(3);
        send(50, 80, 0);
        idle();
        expect_px("we_next_frame", 0, 0, 0);

        // Mid-stream switch bypass -> grayscale at p2
        commit(0);
        send(1, 2, 3);
        send(200, 100, 50);
        drive(1, 100, 100, 100, 1, 2, 0, 0, 0);
        send(255, 0, 0);
        idle();
        expect_px("mid_p0", 1, 2, 3);
        expect_px("mid_p1", 200, 100, 50);
        expect_px("mid_p2", 100, 100, 100);
        expect_px("mid_p3", GRAY_RED, GRAY_RED, GRAY_RED);

        // Reset with three pixels in flight
        commit(1);
        send(10, 20, 30);
        send(40, 50, 60);
        send(70, 80, 90);
        idle();
        got.delete();
        #2 rst = 1'b0;
        #1;
        check("async_rst_valid", int'(out_valid), 0);
        check("async_rst_r", int'(r_out), 0);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        repeat (8) idle();
        check("no_stale_pixel", got.size(), 0);

        send(10, 20, 30);
        idle();
        expect_px("post_rst_bypass", 10, 20, 30);
        commit(3);
        send(50, 80, 0);
        idle();
        expect_px("post_rst_identity", 50, 80, 0);

        repeat (3) idle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/color_matrix_pipe.md
Name: color_matrix_pipe

Overview:
- Parametrised, 4-stage pipelined 3x3 colour-matrix transform for the video path; successor to the fixed sepia converter.
- Selectable modes: bypass, sepia, grayscale, custom. Custom coefficients are programmable and double-buffered.
- Mode and coefficient changes take effect only at frame_start, so a frame never tears.
- Sits between pixel source and display/filter stages; carries a valid qualifier alongside the data.

Parameters:
- DATA_W, 8: bits per colour channel (unsigned).
- COEF_W, 10: coefficient width, signed two's complement.
- FRAC_W, 8: fractional bits of each coefficient; 1.0 = 2^FRAC_W.

Ports:
- clk  in  1  system clock; all state on posedge.
- rst  in  1  asynchronous, active-low reset; asserted when 0.
- in_valid  in  1  input pixel qualifier.
- r_in, g_in, b_in  in  DATA_W each  input pixel.
- frame_start  in  1  one-cycle pulse; commits shadow config to the active config.
- mode  in  2  requested mode: 0 bypass, 1 sepia, 2 grayscale, 3 custom; sampled only at frame_start.
- cfg_we  in  1  shadow coefficient write strobe.
- cfg_addr  in  4  coefficient index 0..8, row-major: 0-2 R row, 3-5 G row, 6-8 B row; 9-15 ignored.
- cfg_data  in  COEF_W  coefficient value.
- out_valid  out  1  output pixel qualifier.
- r_out, g_out, b_out  out  DATA_W each  transformed pixel.

Behaviour:
- Reset (rst=0, async):
  - out_valid=0; r_out/g_out/b_out=0; all pipeline valid bits and data = 0.
  - Active mode = bypass.
  - Shadow and active custom banks = identity: diagonal 2^FRAC_W, off-diagonal 0.
- Built-in matrices, valid for FRAC_W=8 (constants scale by 2^(FRAC_W-8)):
  - Sepia rows: R 101,197,48; G 89,176,43; B 70,137,33.
  - Grayscale: all three rows 77,150,29.
- Config commit:
  - On a cycle with frame_start=1, active_mode <= mode and active_bank <= shadow_bank.
  - A pixel with in_valid in the same cycle as frame_start already uses the new config (stage 1 selects the next-active value).
  - A cfg_we in the same cycle as frame_start updates shadow after the copy; it takes effect at the next frame_start.
  - cfg_we with cfg_addr>8 has no effect.
- Pipeline, fixed latency 4: out_valid(t+4) = in_valid(t). No backpressure.
  - S1: latch pixel and the selected 9 coefficients (from active or next-active config). In-flight pixels keep their own coefficients.
  - S2: 9 signed products, pixel zero-extended; product width DATA_W+COEF_W+1.
  - S3: per-row sum of 3 products, full precision (+2 bits), no intermediate truncation.
  - S4: arithmetic shift right by FRAC_W (floor), then clamp: <0 -> 0, >2^DATA_W-1 -> 2^DATA_W-1.
- Stage data registers load only when that stage's valid bit is set; otherwise they hold. Outputs hold the last valid pixel while out_valid=0.
- Bypass mode: the output equals the input, with the same 4-cycle latency and the same valid timing.
- Back-to-back valid pixels are accepted every cycle; throughput is 1 pixel/clk.

Optional Feature:
- CMX_ROUND_EN defined: S3 adds 2^(FRAC_W-1) to each row sum before the S4 shift, giving round-half-up. The clamp is unchanged.
- CMX_ROUND_EN undefined: pure floor (truncation); no adder is present.
- Latency is 4 in both builds.

Test Plan:
- Reset, then in (10,20,30) valid at cycle t -> out_valid=1 at t+4 with (10,20,30); out_valid=0 at every other cycle; outputs 0 before the first pixel.
- frame_start with mode=1, then (100,150,200) -> (192,171,133), both builds.
- Sepia, (255,255,255) -> (255,255,239), checking the clamp. Sepia, (2,0,0) -> R=0 without CMX_ROUND_EN, R=1 with it.
- Custom negative coefficient and commit timing:
  - Write addr0=256, addr1=-256 (0x300), identity elsewhere, then frame_start with mode=3.
  - Input (50,80,0) -> (0,80,0).
  - The same writes without frame_start leave the output in the prior mode.
- Mid-stream switch:
  - Pixels p0..p3 back-to-back in bypass; frame_start with mode=2 coincident with p2.
  - p0 and p1 come out unchanged; p2 and p3 come out grayscale, e.g. (100,100,100) -> (100,100,100) and (255,0,0) -> (76,76,76).
  - A cfg_we in the same cycle as frame_start is not visible until the next frame_start.
- Reset mid-operation:
  - Drop rst with 3 pixels in flight -> out_valid=0 immediately and no stale pixel emerges after release.
  - The mode reads back as bypass, and custom mode after frame_start is the identity.
